// File: rtl/wavelet_pkg.sv
// Shared defaults and FSM encoding for the wavelet scheduler and its tap register.
package wavelet_pkg;

  localparam int DEFAULT_BITS_PER_ELEM  = 8;
  localparam int DEFAULT_NUM_ELEM       = 7;
  localparam int DEFAULT_NUM_FILTERS    = 8;
  localparam int DEFAULT_SUM_TRUNCATION = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WAIT = 2'd2,
    EMIT = 2'd3
  } state_t;

endpackage

// File: rtl/wavelet_scheduler_tap_shift_reg.sv
// Tap delay line: on enable, element 0 takes the new sample and every other
// element takes its lower neighbour; the oldest element falls off the top.
module tap_shift_reg
  import wavelet_pkg::*;
#(
  parameter int WIDTH = DEFAULT_BITS_PER_ELEM,
  parameter int DEPTH = DEFAULT_NUM_ELEM
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH*DEPTH-1:0] taps
);

  logic [WIDTH*DEPTH-1:0] shifted;

  generate
    if (DEPTH > 1) begin : g_shift
      assign shifted = {taps[WIDTH*(DEPTH-1)-1:0], din};
    end else begin : g_single
      assign shifted = din;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      taps <= '0;
    end else if (en) begin
      taps <= shifted;
    end
  end

endmodule

// File: rtl/wavelet_scheduler.sv
// Accepts one sample per frame, strobes the filter bank, snapshots all filter
// outputs and serialises them one per handshake; samples offered while busy are dropped.
module wavelet_scheduler
  import wavelet_pkg::*;
#(
  parameter int BITS_PER_ELEM  = DEFAULT_BITS_PER_ELEM,
  parameter int NUM_ELEM       = DEFAULT_NUM_ELEM,
  parameter int NUM_FILTERS    = DEFAULT_NUM_FILTERS,
  parameter int SUM_TRUNCATION = DEFAULT_SUM_TRUNCATION,
  localparam int SEL_W         = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [BITS_PER_ELEM-1:0]     i_sample,
  input  logic                                i_sample_valid,
  output logic                                o_sample_ready,
  output logic [NUM_ELEM*BITS_PER_ELEM-1:0]   o_taps,
  output logic                                o_start_calc,
  input  logic [NUM_FILTERS*SUM_TRUNCATION-1:0] i_wavelets,
  output logic [SUM_TRUNCATION-1:0]           o_data,
  output logic                                o_data_valid,
  input  logic                                i_data_ready,
  output logic [SEL_W-1:0]                    o_filter_sel,
  output logic [7:0]                          o_drop_count
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_FILTERS - 1);

  state_t                    state, state_nxt;
  logic [SEL_W-1:0]          idx;
  logic [SUM_TRUNCATION-1:0] snap [NUM_FILTERS];
  logic                      accept;
  logic                      drop;

  assign accept = (state == IDLE) && i_sample_valid;
  assign drop   = (state != IDLE) && i_sample_valid;

  tap_shift_reg #(
    .WIDTH (BITS_PER_ELEM),
    .DEPTH (NUM_ELEM)
  ) u_taps (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (i_sample),
    .taps (o_taps)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    o_sample_ready = 1'b0;
    o_start_calc   = 1'b0;
    o_data_valid   = 1'b0;
    o_data         = '0;
    o_filter_sel   = '0;
    case (state)
      IDLE: begin
        o_sample_ready = 1'b1;
        if (i_sample_valid) state_nxt = CALC;
      end
      CALC: begin
        o_start_calc = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: begin
        state_nxt = EMIT;
      end
      EMIT: begin
        o_data       = snap[idx];
        o_filter_sel = idx;
        o_data_valid = 1'b1;
        if (i_data_ready && (idx == LAST_IDX)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot freezes the filter outputs so later bank activity cannot leak into the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_FILTERS; k++) snap[k] <= '0;
    end else if (state == WAIT) begin
      for (int k = 0; k < NUM_FILTERS; k++) begin
        snap[k] <= i_wavelets[SUM_TRUNCATION*k +: SUM_TRUNCATION];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (state == WAIT) begin
      idx <= '0;
    end else if ((state == EMIT) && i_data_ready) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_drop_count <= '0;
    end else if (drop && (o_drop_count != 8'hFF)) begin
      o_drop_count <= o_drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_wavelet_scheduler.sv
// Directed bench for wavelet_scheduler: reset, single/sequence frames, backpressure,
// drop-count saturation and mid-frame reset.
module tb_wavelet_scheduler;

  localparam logic [63:0] WL = 64'h8776_6554_4332_2110;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_sample;
  logic        i_sample_valid;
  logic        o_sample_ready;
  logic [55:0] o_taps;
  logic        o_start_calc;
  logic [63:0] i_wavelets;
  logic [7:0]  o_data;
  logic        o_data_valid;
  logic        i_data_ready;
  logic [2:0]  o_filter_sel;
  logic [7:0]  o_drop_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wavelet_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .o_sample_ready (o_sample_ready),
    .o_taps         (o_taps),
    .o_start_calc   (o_start_calc),
    .i_wavelets     (i_wavelets),
    .o_data         (o_data),
    .o_data_valid   (o_data_valid),
    .i_data_ready   (i_data_ready),
    .o_filter_sel   (o_filter_sel),
    .o_drop_count   (o_drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!o_sample_ready && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_ready_timeout"}, o_sample_ready, 1);
  endtask

  // One full frame; filter outputs are scrambled once EMIT starts to prove the snapshot holds.
  task automatic run_frame(input logic [7:0] s, input bit toggle);
    logic [7:0] e;
    wait_ready("frame");
    i_sample       = s;
    i_sample_valid = 1'b1;
    step();
    i_sample_valid = 1'b0;
    chk("calc_strobe", o_start_calc, 1);
    chk("ready_low_calc", o_sample_ready, 0);
    chk("tap_elem0", o_taps[7:0], s);
    step();
    chk("calc_one_cycle", o_start_calc, 0);
    chk("valid_low_wait", o_data_valid, 0);
    step();
    i_wavelets = ~WL;
    for (int k = 0; k < 8; k++) begin
      e = 8'(8'h10 + 8'h11 * k);
      chk("emit_valid", o_data_valid, 1);
      chk("emit_sel", o_filter_sel, k);
      chk("emit_data", o_data, e);
      if (toggle) begin
        i_data_ready = 1'b0;
        step();
        chk("hold_valid", o_data_valid, 1);
        chk("hold_sel", o_filter_sel, k);
        chk("hold_data", o_data, e);
        i_data_ready = 1'b1;
      end
      step();
    end
    chk("post_valid", o_data_valid, 0);
    chk("post_ready", o_sample_ready, 1);
    chk("post_data", o_data, 0);
    chk("post_sel", o_filter_sel, 0);
    i_wavelets = WL;
  endtask

  initial begin
    int frames, beats, drops_model, exp_sel, n;
    bit seen;

    rst            = 1'b1;
    i_sample       = 8'h33;
    i_sample_valid = 1'b1;
    i_data_ready   = 1'b1;
    i_wavelets     = WL;
    step();
    step();
    rst            = 1'b0;
    i_sample_valid = 1'b0;
    chk("rst_taps", o_taps, 0);
    chk("rst_drop", o_drop_count, 0);
    chk("rst_ready", o_sample_ready, 1);
    chk("rst_valid", o_data_valid, 0);
    chk("rst_start", o_start_calc, 0);
    chk("rst_data", o_data, 0);
    chk("rst_sel", o_filter_sel, 0);
    step();
    chk("rst_sample_ignored", o_taps, 0);

    run_frame(8'h05, 1'b0);
    chk("taps_single", o_taps, 56'h00_0000_0000_0005);

    for (int s = 1; s <= 7; s++) run_frame(8'(s), 1'b0);
    chk("taps_seq", o_taps, 56'h01_0203_0405_0607);

    run_frame(8'h08, 1'b1);
    chk("taps_after_toggle", o_taps, 56'h02_0304_0506_0708);
    chk("no_drops_yet", o_drop_count, 0);

    // Continuous valid: every frame must complete, drops saturate.
    frames      = 0;
    beats       = 0;
    drops_model = 0;
    exp_sel     = 0;
    for (int i = 0; i < 300; i++) begin
      i_sample       = 8'(i);
      i_sample_valid = 1'b1;
      if (i == 100) chk("drop_partial", o_drop_count, drops_model);
      if (o_data_valid) begin
        chk("sat_sel", o_filter_sel, exp_sel);
        exp_sel = (exp_sel + 1) % 8;
        beats++;
      end
      if (o_sample_ready) frames++;
      else drops_model++;
      step();
    end
    i_sample_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_data_valid) begin
        chk("sat_sel", o_filter_sel, exp_sel);
        exp_sel = (exp_sel + 1) % 8;
        beats++;
      end
      step();
    end
    chk("sat_beats", beats, frames * 8);
    chk("sat_drop_model", o_drop_count, (drops_model > 255) ? 255 : drops_model);
    chk("sat_drop", o_drop_count, 255);

    // Reset mid-EMIT at filter 3.
    wait_ready("rst_emit");
    i_sample       = 8'h44;
    i_sample_valid = 1'b1;
    step();
    i_sample_valid = 1'b0;
    n = 0;
    while (!(o_data_valid && o_filter_sel == 3) && n < 20) begin
      step();
      n++;
    end
    chk("reach_sel3", o_filter_sel, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_valid", o_data_valid, 0);
    chk("abort_taps", o_taps, 0);
    chk("abort_ready", o_sample_ready, 1);
    chk("abort_drop", o_drop_count, 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (o_data_valid || o_start_calc) seen = 1'b1;
      step();
    end
    chk("abort_quiet", seen, 0);

    // Reset during CALC.
    i_sample       = 8'h11;
    i_sample_valid = 1'b1;
    step();
    i_sample_valid = 1'b0;
    chk("calc_before_rst", o_start_calc, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (o_data_valid) seen = 1'b1;
      step();
    end
    chk("calc_abort_quiet", seen, 0);
    chk("calc_abort_taps", o_taps, 0);

    run_frame(8'h22, 1'b1);
    chk("recover_taps", o_taps, 56'h00_0000_0000_0022);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wavelet_scheduler.md
WAVELET_SCHEDULER -- requirements
Module: wavelet_scheduler

Interface
REQ-001 Parameter BITS_PER_ELEM, default 8, width of each input sample and each tap element.
REQ-002 Parameter NUM_ELEM, default 7, number of tap elements presented to the filter bank.
REQ-003 Parameter NUM_FILTERS, default 8, number of fir instances whose outputs are collected.
REQ-004 Parameter SUM_TRUNCATION, default 8, width of each filter output and of o_data.
REQ-005 Port clk, input, 1, sole clock; all logic SHALL be rising-edge clocked.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port i_sample, input, BITS_PER_ELEM, signed input sample.
REQ-008 Port i_sample_valid, input, 1, i_sample is valid this cycle.
REQ-009 Port o_sample_ready, output, 1, block accepts a sample this cycle.
REQ-010 Port o_taps, output, NUM_ELEM*BITS_PER_ELEM, tap vector to all filters; element i at bits [BITS_PER_ELEM*i +: BITS_PER_ELEM].
REQ-011 Port o_start_calc, output, 1, single-cycle calculation strobe to all filters.
REQ-012 Port i_wavelets, input, NUM_FILTERS*SUM_TRUNCATION, concatenated filter outputs; filter k at bits [SUM_TRUNCATION*k +: SUM_TRUNCATION].
REQ-013 Port o_data, output, SUM_TRUNCATION, serialized filter result.
REQ-014 Port o_data_valid, output, 1, o_data is valid.
REQ-015 Port i_data_ready, input, 1, downstream accepts o_data.
REQ-016 Port o_filter_sel, output, clog2(NUM_FILTERS), index k of the filter currently on o_data.
REQ-017 Port o_drop_count, output, 8, saturating count of rejected samples.

Function
REQ-018 FSM SHALL have states IDLE, CALC, WAIT, EMIT.
REQ-019 o_sample_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE with i_sample_valid=1: taps shift (element i <= element i-1 for i>=1, element 0 <= i_sample, element NUM_ELEM-1 discarded); next state CALC.
REQ-021 In CALC, o_start_calc SHALL be 1 for exactly that cycle; next state WAIT; o_start_calc SHALL be 0 in every other state.
REQ-022 In WAIT, the block SHALL capture i_wavelets into an internal snapshot register at the end of the cycle, reset the emit index to 0; next state EMIT.
REQ-023 In EMIT, o_data SHALL equal snapshot element [index], o_filter_sel SHALL equal index, o_data_valid SHALL be 1.
REQ-024 In EMIT, on i_data_ready=1 index increments; if index = NUM_FILTERS-1, next state IDLE instead.
REQ-025 In EMIT with i_data_ready=0, o_data, o_filter_sel and o_data_valid SHALL hold stable.
REQ-026 o_data_valid SHALL be 0 outside EMIT; o_data and o_filter_sel SHALL be 0 outside EMIT.
REQ-027 Latency: sample accepted at edge N → o_start_calc high cycle N+1 → snapshot captured end of N+2 → first o_data_valid cycle N+3.
REQ-028 i_sample_valid=1 while o_sample_ready=0 SHALL drop the sample, leave taps unchanged, and increment o_drop_count, saturating at 255.
REQ-029 o_taps SHALL change only on an accepted sample; the snapshot SHALL change only in WAIT.
REQ-030 Taps are treated as raw bits; no arithmetic is performed on samples or results.

Reset
REQ-031 On rst=1 at a clock edge: state IDLE, taps 0, snapshot 0, index 0, o_drop_count 0, o_start_calc 0, o_data_valid 0, o_data 0, o_filter_sel 0.
REQ-032 rst asserted mid-EMIT or mid-CALC SHALL abort the frame; no further o_data_valid until a new sample is accepted.
REQ-033 A sample presented in the cycle rst=1 SHALL not be accepted or counted.

Structure
REQ-034 Shared package wavelet_pkg SHALL hold parameter defaults (BITS_PER_ELEM, NUM_ELEM, NUM_FILTERS, SUM_TRUNCATION) and FSM state encodings.
REQ-035 The tap shift register SHALL be a sub-module tap_shift_reg (enable, data in, parallel out).
REQ-036 The FSM, snapshot register, output mux and drop counter SHALL reside in wavelet_scheduler.

Verification
REQ-037 After reset, one sample 0x05 → o_taps element 0 = 0x05, others 0; o_start_calc pulses exactly one cycle, one cycle after acceptance.
REQ-038 Seven samples 1..7, i_data_ready=1 → o_taps element 0 = 7, element 6 = 1; 8 outputs per sample with o_filter_sel 0..7 on consecutive cycles.
REQ-039 i_wavelets = {0x87,0x76,...,0x10} with i_data_ready toggling 1/0 → o_data sequence 0x10..0x87 in order, each held while ready=0; i_wavelets changed after WAIT has no effect.
REQ-040 i_sample_valid held 1 continuously for 300 cycles → every frame fully emitted; o_drop_count saturates at 255.
REQ-041 rst=1 during EMIT at o_filter_sel=3 → next cycle o_data_valid=0, o_taps=0, state IDLE, o_sample_ready=1.
